dmem_readout_ctrl: RTL and testbench

- Hardware unload engine for data memory: after the core asserts END, it walks an address window of data memory and streams each word out over a valid/ready interface.
- It drives the top-level address mux (select 2 = external readout address) and the AR-side address input.
- Replaces the manual dump loop used at bench level, so result matrices can be drained to a host or UART bridge.

---
 rtl/dmem_readout_ctrl_if.sv | 26 ++
 rtl/dmem_readout_ctrl.sv | 74 +++++++
 tb/tb_dmem_readout_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_readout_ctrl_if.sv
// dmem_readout_ctrl_if: control, data-memory and stream signals of the readout engine
interface dmem_readout_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [1:0]        addr_mux_select;
    logic [ADDR_W-1:0] ar_out;
    logic [DATA_W-1:0] dmem_rdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] word_count;
    modport master (
        input  start, start_addr, end_addr, dmem_rdata, out_ready,
        output addr_mux_select, ar_out, out_data, out_valid, busy, done, word_count
    );
    modport slave (
        output start, start_addr, end_addr, dmem_rdata, out_ready,
        input  addr_mux_select, ar_out, out_data, out_valid, busy, done, word_count
    );
endinterface

// File: rtl/dmem_readout_ctrl.sv
// dmem_readout_ctrl: walks a data-memory window [start_addr, end_addr) and streams each word out
module dmem_readout_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 1
) (
    input logic clk,
    input logic RESET,
    dmem_readout_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, ADDR, WAIT, HOLD, DONE} state_t;
    localparam logic [ADDR_W-1:0] one = 1;
    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] last;
    logic [2:0]        cnt;
    always_ff @(posedge clk) begin
        if (RESET) begin
            state               <= IDLE;
            addr                <= '0;
            last                <= '0;
            cnt                 <= '0;
            bus.addr_mux_select <= 2'd0;
            bus.ar_out          <= '0;
            bus.out_data        <= '0;
            bus.out_valid       <= 1'b0;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.word_count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        addr           <= bus.start_addr;
                        last           <= bus.end_addr;
                        bus.word_count <= '0;
                        bus.busy       <= 1'b1;
                        state          <= (bus.start_addr >= bus.end_addr) ? DONE : ADDR;
                    end
                end
                ADDR: begin
                    bus.addr_mux_select <= 2'd2;
                    bus.ar_out          <= addr;
                    cnt                 <= MEM_LATENCY[2:0];
                    state               <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        bus.out_data  <= bus.dmem_rdata;
                        bus.out_valid <= 1'b1;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid  <= 1'b0;
                        bus.word_count <= bus.word_count + one;
                        addr           <= (addr + one == last) ? addr : addr + one;
                        state          <= (addr + one == last) ? DONE : ADDR;
                    end
                end
                DONE: begin
                    bus.done            <= 1'b1;
                    bus.addr_mux_select <= 2'd0;
                    bus.busy            <= 1'b0;
                    state               <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_readout_ctrl.sv
// tb_dmem_readout_ctrl: directed checks of the readout engine with a scoreboard on the stream
module tb_dmem_readout_ctrl;
    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad = 0;
    int dones = 0;
    int vcycles = 0;
    logic [15:0] mem [0:1023];
    logic [15:0] q1 [$];
    logic [17:0] prev3;
    int age3 = 0;

    dmem_readout_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();
    dmem_readout_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus3 ();

    dmem_readout_ctrl #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(1)) u1 (.clk(clk), .RESET(rst), .bus(bus1));
    dmem_readout_ctrl #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(3)) u3 (.clk(clk), .RESET(rst), .bus(bus3));

    always #5 clk = ~clk;

    // single-cycle memory for u1; u3 sees junk until the address has been stable for 3 cycles
    assign bus1.dmem_rdata = mem[bus1.ar_out[9:0]];
    assign bus3.dmem_rdata = (({bus3.addr_mux_select, bus3.ar_out} === prev3) && age3 >= 1) ? mem[bus3.ar_out[9:0]] : 16'hDEAD;
    always @(posedge clk) begin
        age3  <= ({bus3.addr_mux_select, bus3.ar_out} === prev3) ? ((age3 < 100) ? age3 + 1 : age3) : 0;
        prev3 <= {bus3.addr_mux_select, bus3.ar_out};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start1(input logic [15:0] s, input logic [15:0] e);
        bus1.start_addr = s;
        bus1.end_addr = e;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
    endtask

    task automatic push(input int s, input int e);
        for (int a = s; a < e; a++) q1.push_back(mem[a]);
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (bus1.done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        chk("done_timeout", bus1.done, 1);
    endtask

    always @(negedge clk) begin
        if (bus1.done === 1'b1) dones++;
        if (bus1.out_valid === 1'b1) vcycles++;
        if (bus1.out_valid === 1'b1 && bus1.out_ready === 1'b1) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $error("FAIL sb_extra_word observed=%0h expected=none", bus1.out_data);
            end else chk("sb_word", bus1.out_data, q1.pop_front());
        end
    end

    initial begin
        int d0, v0, n;
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 13 + 5);
        mem[200] = 16'd11; mem[201] = 16'd22; mem[202] = 16'd33; mem[203] = 16'd44;
        mem[0] = 16'd7; mem[1] = 16'd9;
        rst = 1'b1;
        bus1.start = 1'b0; bus1.start_addr = '0; bus1.end_addr = '0; bus1.out_ready = 1'b1;
        bus3.start = 1'b0; bus3.start_addr = '0; bus3.end_addr = '0; bus3.out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_mux", bus1.addr_mux_select, 0);
        chk("rst_ar", bus1.ar_out, 0);
        chk("rst_data", bus1.out_data, 0);
        chk("rst_valid", bus1.out_valid, 0);
        chk("rst_busy", bus1.busy, 0);
        chk("rst_done", bus1.done, 0);
        chk("rst_count", bus1.word_count, 0);

        // basic drain
        d0 = dones; v0 = vcycles;
        push(200, 204);
        start1(200, 204);
        chk("basic_busy", bus1.busy, 1);
        tick(); tick();
        chk("basic_first_valid", bus1.out_valid, 1);
        chk("basic_mux_run", bus1.addr_mux_select, 2);
        wait_done(40);
        chk("basic_count", bus1.word_count, 4);
        chk("basic_mux_after", bus1.addr_mux_select, 0);
        tick();
        chk("basic_done_pulse", bus1.done, 0);
        chk("basic_busy_after", bus1.busy, 0);
        chk("basic_done_count", dones - d0, 1);
        chk("basic_valid_cycles", vcycles - v0, 4);
        chk("basic_sb_empty", q1.size(), 0);

        // backpressure on the first word
        d0 = dones;
        bus1.out_ready = 1'b0;
        push(200, 204);
        start1(200, 204);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", bus1.out_valid, 1);
            chk("bp_data", bus1.out_data, 11);
            chk("bp_ar", bus1.ar_out, 200);
            tick();
        end
        bus1.out_ready = 1'b1;
        wait_done(40);
        chk("bp_count", bus1.word_count, 4);
        chk("bp_sb_empty", q1.size(), 0);
        tick();
        chk("bp_done_count", dones - d0, 1);

        // empty then inverted window
        v0 = vcycles;
        start1(50, 50);
        chk("empty_busy", bus1.busy, 1);
        chk("empty_mux1", bus1.addr_mux_select, 0);
        tick();
        chk("empty_done", bus1.done, 1);
        chk("empty_mux2", bus1.addr_mux_select, 0);
        chk("empty_count", bus1.word_count, 0);
        start1(60, 10);
        chk("inv_mux1", bus1.addr_mux_select, 0);
        tick();
        chk("inv_done", bus1.done, 1);
        chk("inv_mux2", bus1.addr_mux_select, 0);
        chk("inv_count", bus1.word_count, 0);
        chk("empty_no_valid", vcycles - v0, 0);
        tick();

        // latency 3 instance
        bus3.start_addr = 16'd0; bus3.end_addr = 16'd2; bus3.start = 1'b1;
        tick();
        bus3.start = 1'b0;
        tick(); chk("lat_valid_c2", bus3.out_valid, 0);
        tick(); chk("lat_valid_c3", bus3.out_valid, 0);
        tick(); chk("lat_valid_c4", bus3.out_valid, 0);
        tick();
        chk("lat_valid_c5", bus3.out_valid, 1);
        chk("lat_data0", bus3.out_data, 7);
        for (int i = 0; i < 5; i++) tick();
        chk("lat_valid_w1", bus3.out_valid, 1);
        chk("lat_data1", bus3.out_data, 9);
        tick(); tick();
        chk("lat_done", bus3.done, 1);
        chk("lat_count", bus3.word_count, 2);

        // reset in the middle of a long run
        push(0, 210);
        start1(0, 210);
        n = 0;
        while (bus1.word_count !== 16'd3 && n < 50) begin
            tick();
            n++;
        end
        chk("mid_count3", bus1.word_count, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_valid", bus1.out_valid, 0);
        chk("mid_mux", bus1.addr_mux_select, 0);
        chk("mid_count", bus1.word_count, 0);
        chk("mid_busy", bus1.busy, 0);
        chk("mid_sb_left", q1.size(), 207);
        q1.delete();
        push(0, 2);
        start1(0, 2);
        wait_done(40);
        chk("post_rst_count", bus1.word_count, 2);
        chk("post_rst_sb_empty", q1.size(), 0);
        tick();

        // start pulse while busy
        d0 = dones;
        push(0, 4);
        start1(0, 4);
        tick(); tick();
        bus1.start_addr = 16'd500; bus1.end_addr = 16'd600; bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        wait_done(40);
        chk("busy_start_count", bus1.word_count, 4);
        chk("busy_start_sb_empty", q1.size(), 0);
        tick(); tick(); tick(); tick();
        chk("busy_start_done_count", dones - d0, 1);
        chk("busy_start_idle", bus1.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
